// File: rtl/mem_arbiter_if.sv
// Request/response and memory-side signals of mem_arbiter, bundled for port connection.
// slave: arbiter side; master: requesters plus memory model side.
interface mem_arbiter_if #(
    parameter int unsigned W = 32,
    parameter int unsigned A = 12
);
    logic         req0;
    logic         we0;
    logic [A-1:0] addr0;
    logic [W-1:0] wdata0;
    logic [W-1:0] rdata0;
    logic         ack0;

    logic         req1;
    logic         we1;
    logic [A-1:0] addr1;
    logic [W-1:0] wdata1;
    logic [W-1:0] rdata1;
    logic         ack1;

    logic [A-1:0] mem_addr;
    logic         mem_write;
    logic [W-1:0] mem_wdata;
    logic [W-1:0] mem_rdata;
    logic         busy;

    modport slave (
        input  req0, we0, addr0, wdata0,
        output rdata0, ack0,
        input  req1, we1, addr1, wdata1,
        output rdata1, ack1,
        output mem_addr, mem_write, mem_wdata,
        input  mem_rdata,
        output busy
    );

    modport master (
        output req0, we0, addr0, wdata0,
        input  rdata0, ack0,
        output req1, we1, addr1, wdata1,
        input  rdata1, ack1,
        input  mem_addr, mem_write, mem_wdata,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter/sequencer for a single-port memory with LAT-cycle accesses.
// Define MEM_ARB_FIXED_PRIO_EN to make port 0 always win simultaneous requests.
module mem_arbiter #(
    parameter int unsigned W   = 32,
    parameter int unsigned A   = 12,
    parameter int unsigned LAT = 1
) (
    input logic             clk,
    input logic             rst_n,
    mem_arbiter_if.slave    bus
);

    if (LAT < 1 || LAT > 15) begin : g_lat_check
        $error("mem_arbiter: LAT must be in 1..15");
    end

    localparam logic [3:0] CountInit = 4'(LAT - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_t;

    state_t     state;
    logic [3:0] count;
    logic       port_q;
    logic       we_q;
`ifndef MEM_ARB_FIXED_PRIO_EN
    logic       rr_ptr;
`endif

    logic         gnt_any;
    logic         gnt_port;
    logic         sel_we;
    logic [A-1:0] sel_addr;
    logic [W-1:0] sel_wdata;

    always_comb begin
        gnt_any = bus.req0 | bus.req1;
`ifdef MEM_ARB_FIXED_PRIO_EN
        gnt_port = ~bus.req0;
`else
        gnt_port = bus.req1 & (~bus.req0 | rr_ptr);
`endif
        sel_we    = gnt_port ? bus.we1    : bus.we0;
        sel_addr  = gnt_port ? bus.addr1  : bus.addr0;
        sel_wdata = gnt_port ? bus.wdata1 : bus.wdata0;
    end

    // All outputs are registered; mem_write is set one edge ahead of the final ACCESS cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= StIdle;
            count         <= '0;
            port_q        <= 1'b0;
            we_q          <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            rr_ptr        <= 1'b0;
`endif
            bus.mem_addr  <= '0;
            bus.mem_write <= 1'b0;
            bus.mem_wdata <= '0;
            bus.rdata0    <= '0;
            bus.rdata1    <= '0;
            bus.ack0      <= 1'b0;
            bus.ack1      <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (gnt_any) begin
                        port_q        <= gnt_port;
                        we_q          <= sel_we;
                        bus.mem_addr  <= sel_addr;
                        bus.mem_wdata <= sel_wdata;
                        count         <= CountInit;
                        bus.mem_write <= (LAT == 1) && sel_we;
                        bus.busy      <= 1'b1;
                        state         <= StAccess;
                    end
                end
                StAccess: begin
                    if (count == 4'd0) begin
                        // Memory writes at this edge, so the read still sees the old word.
                        bus.mem_write <= 1'b0;
                        if (port_q) begin
                            bus.rdata1 <= bus.mem_rdata;
                            bus.ack1   <= 1'b1;
                        end else begin
                            bus.rdata0 <= bus.mem_rdata;
                            bus.ack0   <= 1'b1;
                        end
                        state <= StResp;
                    end else begin
                        count         <= count - 4'd1;
                        bus.mem_write <= we_q && (count == 4'd1);
                    end
                end
                StResp: begin
                    bus.ack0 <= 1'b0;
                    bus.ack1 <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
                    rr_ptr   <= ~port_q;
`endif
                    bus.busy <= 1'b0;
                    state    <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
